mips_regfile_alu: RTL and testbench
===================================

Name: mips_regfile_alu

Overview:
- Register-file plus execute slice of the multicycle MIPS datapath.
- Contains three parts:
  - a 32x32 three-port register file (two combinational reads, one synchronous write);
  - a 2:1 source-B select mux choosing between register data and the sign-extended immediate;
  - a 32-bit ALU with a zero flag.
- Sits between instruction decode (register addresses, immediate, control) and the ALUOut/PC/writeback logic.

Parameters:
- WIDTH, 32, data width of registers, ALU operands and result.
- ADDR_W, 5, register address width; the register count is 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- we3  input  1  register write enable.
- ra1  input  ADDR_W  read address, port 1 (rs).
- ra2  input  ADDR_W  read address, port 2 (rt).
- wa3  input  ADDR_W  write address.
- wd3  input  WIDTH  write data.
- alusrc  input  1  source-B select: 0 = rd2, 1 = imm.
- imm  input  WIDTH  sign-extended immediate.
- alucontrol  input  3  ALU operation.
- rd1  output  WIDTH  register read data, port 1; also ALU srcA.
- rd2  output  WIDTH  register read data, port 2; also the store write data.
- aluresult  output  WIDTH  combinational ALU result.
- zero  output  1  1 when aluresult == 0.

Behaviour:
- Reset: while reset is 0, all registers clear to 0 asynchronously. rd1/rd2 therefore read 0 and outputs follow combinationally (e.g. ADD 0+0 gives aluresult = 0, zero = 1). A reset asserted mid-operation wins over a same-cycle write.
- Register 0: hardwired to 0. Writes to address 0 are ignored; reading address 0 always returns 0.
- Write: on the rising edge of clk, if reset = 1, we3 = 1 and wa3 != 0, then reg[wa3] <= wd3. No write occurs when we3 = 0.
- Read: rd1 = reg[ra1] and rd2 = reg[ra2], combinational, zero cycles latency.
- Read and write to the same address in the same cycle: the read returns the old value until the clock edge and the new value after it. There is no internal bypass.
- srcB = alusrc ? imm : rd2, implemented with the mux2 sub-module.
- ALU, a = rd1, b = srcB, all results taken modulo 2**WIDTH:
  - 000 AND: a & b.
  - 001 OR: a | b.
  - 010 ADD: a + b, carry discarded.
  - 110 SUB: a - b, wraps.
  - 111 SLT: 1 if a < b as signed two's-complement, else 0. The comparison must be correct under overflow; do not use the sign bit of the difference.
  - 100: a & ~b.
  - 101: a | ~b.
  - 011: result 0.
- zero is computed from aluresult for every operation.
- No overflow or carry outputs; no exceptions.
- All outputs are purely combinational from register state and inputs. The only internal state is the register array.

Decomposition:
- Shared package mips_pkg: ALU control constants ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111, plus the WIDTH/ADDR_W defaults.
- Sub-module mux2: parameterized WIDTH, inputs d0 and d1, select s, output y = s ? d1 : d0. It is reused elsewhere for the write-register and write-data muxes.
- The register array and the ALU stay inline in the top module.

Test Plan:
- Reset: hold reset = 0, with we3 = 1, wa3 = 5, wd3 = 32'hFFFF_FFFF clocked -> after release, ra1 = 5 gives rd1 = 0; ADD with imm = 0 gives aluresult = 0, zero = 1.
- Write/read, including register 0:
  - write 32'h1234_5678 to r3 -> next cycle ra1 = 3 reads it;
  - write 32'hDEAD_BEEF to r0 -> ra2 = 0 reads 0;
  - same-cycle read of r3 while rewriting it with 32'h1 shows 32'h1234_5678 until the edge, then 32'h1.
- ALU ops, with r1 = 32'h0000_00F0 and r2 = 32'h0000_0F0F (alusrc = 0):
  - AND -> 32'h0000_0000, zero = 1;
  - OR -> 32'h0000_0FFF;
  - ADD -> 32'h0000_0FFF;
  - SUB -> 32'hFFFF_F1E1;
  - SLT -> 1.
- Immediate path: alusrc = 1, imm = 32'hFFFF_FFFC, ADD with r1 = 32'h10 -> 32'h0000_000C. Then alusrc = 0 selects rd2.
- Arithmetic edges:
  - ADD 32'hFFFF_FFFF + 1 -> 0, zero = 1;
  - SUB 32'h8000_0000 - 1 -> 32'h7FFF_FFFF;
  - SLT 32'h8000_0000 vs 32'h7FFF_FFFF -> 1;
  - SLT 32'h7FFF_FFFF vs 32'h8000_0000 -> 0;
  - SLT equal operands -> 0, zero = 1.
- Write-enable gating: we3 = 0 with wa3 = 7, wd3 = 32'hA5A5_A5A5 clocked -> r7 is unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS datapath: ALU control encodings
// and the default data/register-address widths.
package mips_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ZERO = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/mips_regfile_alu_mux2.sv
// Generic two-input mux, shared by the source-B, write-register and
// write-data selects of the datapath.
module mux2
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mips_regfile_alu.sv
// Register file plus execute slice: 3-port register array with r0 hardwired
// to zero, immediate/register source-B select and a 32-bit ALU with zero flag.
module mips_regfile_alu
    import mips_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    input  logic              alusrc,
    input  logic [WIDTH-1:0]  imm,
    input  logic [2:0]        alucontrol,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic [WIDTH-1:0]  aluresult,
    output logic              zero
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] srcb;

    // Reset clears the whole array and takes priority over any write issued
    // in the same cycle; address 0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && (wa3 != '0)) begin
            regs[wa3] <= wd3;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the old value.
    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

    mux2 #(.WIDTH(WIDTH)) srcb_mux (
        .d0 (rd2),
        .d1 (imm),
        .s  (alusrc),
        .y  (srcb)
    );

    // SLT uses a true signed compare so it stays correct when a - b overflows.
    always_comb begin
        aluresult = '0;
        case (alucontrol)
            ALU_AND:  aluresult = rd1 & srcb;
            ALU_OR:   aluresult = rd1 | srcb;
            ALU_ADD:  aluresult = rd1 + srcb;
            ALU_SUB:  aluresult = rd1 - srcb;
            ALU_SLT:  aluresult = {{(WIDTH-1){1'b0}}, ($signed(rd1) < $signed(srcb))};
            ALU_ANDN: aluresult = rd1 & ~srcb;
            ALU_ORN:  aluresult = rd1 | ~srcb;
            default:  aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);

endmodule

// File: tb/tb_mips_regfile_alu.sv
// Scoreboard bench for mips_regfile_alu: directed and random operations are
// predicted by an array-based register model and an arithmetic ALU model.
module tb_mips_regfile_alu;

    localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                           OP_SUB = 3'b110, OP_SLT = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3;
    logic [4:0]  ra1, ra2, wa3;
    logic [31:0] wd3, imm;
    logic        alusrc;
    logic [2:0]  alucontrol;
    logic [31:0] rd1, rd2, aluresult;
    logic        zero;

    mips_regfile_alu dut (
        .clk        (clk),
        .reset      (reset),
        .we3        (we3),
        .ra1        (ra1),
        .ra2        (ra2),
        .wa3        (wa3),
        .wd3        (wd3),
        .alusrc     (alusrc),
        .imm        (imm),
        .alucontrol (alucontrol),
        .rd1        (rd1),
        .rd2        (rd2),
        .aluresult  (aluresult),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t        scoreboard[$];
    logic [31:0] model [32];
    int          assertCount = 0;
    int          failCount   = 0;
    bit          pendWe = 1'b0;
    logic [4:0]  pendWa;
    logic [31:0] pendWd;

    function automatic logic [31:0] readModel(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    // Reference ALU from the arithmetic definitions (modulo 2**32, signed compare)
    function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] t;
        longint      sa, sbv;
        sa  = longint'({32'd0, a});
        sbv = longint'({32'd0, b});
        if (a[31]) sa  = sa  - 64'sd4294967296;
        if (b[31]) sbv = sbv - 64'sd4294967296;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: begin t = {32'd0, a} + {32'd0, b}; return t[31:0]; end
            3'b110: begin t = {32'd0, a} + 64'h1_0000_0000 - {32'd0, b}; return t[31:0]; end
            3'b111: return (sa < sbv) ? 32'd1 : 32'd0;
            3'b100: return a & (32'hFFFF_FFFF ^ b);
            3'b101: return a | (32'hFFFF_FFFF ^ b);
            default: return 32'd0;
        endcase
    endfunction

    // The DUT commits the previous cycle's write at the edge just passed.
    task automatic commitPending();
        if (pendWe && reset && pendWa != 5'd0) model[pendWa] = pendWd;
        pendWe = 1'b0;
    endtask

    task automatic setReset(input logic val);
        @(posedge clk); #1;
        commitPending();
        reset = val;
        we3   = 1'b0;
        if (!val) for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic applyStimulus(input string name, input bit we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] a1,
                                 input logic [4:0] a2, input bit src,
                                 input logic [31:0] im, input logic [2:0] op);
        exp_t        e;
        logic [31:0] x, y;
        @(posedge clk); #1;
        commitPending();
        we3 = we; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2;
        alusrc = src; imm = im; alucontrol = op;
        x = readModel(a1);
        y = readModel(a2);
        e.name = name;
        e.rd1  = x;
        e.rd2  = y;
        e.res  = refAlu(op, x, src ? im : y);
        e.zero = (e.res == 32'd0);
        scoreboard.push_back(e);
        pendWe = we && reset;
        pendWa = wa;
        pendWd = wd;
    endtask

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each queued expectation is
    // checked on the falling edge of the cycle it was issued in.
    always @(negedge clk) begin
        exp_t e;
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput(e.name, "rd1", rd1, e.rd1);
            checkOutput(e.name, "rd2", rd2, e.rd2);
            checkOutput(e.name, "aluresult", aluresult, e.res);
            checkOutput(e.name, "zero", {31'd0, zero}, {31'd0, e.zero});
        end
    end

    initial begin
        reset = 1'b0; we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hFFFF_FFFF;
        ra1 = 5'd5; ra2 = 5'd0; alusrc = 1'b1; imm = 32'd0; alucontrol = OP_ADD;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        applyStimulus("reset_hold", 1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, 1, 32'd0, OP_ADD);
        applyStimulus("reset_hold2", 1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, 1, 32'd0, OP_ADD);
        setReset(1'b1);
        applyStimulus("post_reset", 0, 5'd0, 32'd0, 5'd5, 5'd0, 1, 32'd0, OP_ADD);

        applyStimulus("wr_r3", 1, 5'd3, 32'h1234_5678, 5'd3, 5'd0, 0, 32'd0, OP_OR);
        applyStimulus("rd_r3", 1, 5'd0, 32'hDEAD_BEEF, 5'd3, 5'd0, 0, 32'd0, OP_OR);
        applyStimulus("rd_r0", 0, 5'd0, 32'd0, 5'd3, 5'd0, 0, 32'd0, OP_ADD);
        applyStimulus("rmw_r3", 1, 5'd3, 32'h1, 5'd3, 5'd3, 0, 32'd0, OP_AND);
        applyStimulus("after_r3", 0, 5'd0, 32'd0, 5'd3, 5'd3, 0, 32'd0, OP_AND);

        applyStimulus("wr_r1", 1, 5'd1, 32'h0000_00F0, 5'd0, 5'd0, 0, 32'd0, OP_ADD);
        applyStimulus("wr_r2", 1, 5'd2, 32'h0000_0F0F, 5'd1, 5'd0, 0, 32'd0, OP_ADD);
        applyStimulus("op_and", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, OP_AND);
        applyStimulus("op_or",  0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, OP_OR);
        applyStimulus("op_add", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, OP_ADD);
        applyStimulus("op_sub", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, OP_SUB);
        applyStimulus("op_slt", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, OP_SLT);
        applyStimulus("op_andn", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, 3'b100);
        applyStimulus("op_orn", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, 3'b101);
        applyStimulus("op_011", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, 3'b011);

        applyStimulus("wr_r1_10", 1, 5'd1, 32'h10, 5'd0, 5'd0, 0, 32'd0, OP_ADD);
        applyStimulus("imm_add", 0, 5'd0, 32'd0, 5'd1, 5'd2, 1, 32'hFFFF_FFFC, OP_ADD);
        applyStimulus("reg_add", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'hFFFF_FFFC, OP_ADD);

        applyStimulus("wr_ones", 1, 5'd1, 32'hFFFF_FFFF, 5'd0, 5'd0, 0, 32'd0, OP_ADD);
        applyStimulus("add_wrap", 1, 5'd1, 32'h8000_0000, 5'd1, 5'd0, 1, 32'd1, OP_ADD);
        applyStimulus("sub_wrap", 1, 5'd2, 32'h7FFF_FFFF, 5'd1, 5'd0, 1, 32'd1, OP_SUB);
        applyStimulus("slt_neg", 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 32'd0, OP_SLT);
        applyStimulus("slt_pos", 0, 5'd0, 32'd0, 5'd2, 5'd1, 0, 32'd0, OP_SLT);
        applyStimulus("slt_eq", 0, 5'd0, 32'd0, 5'd2, 5'd2, 0, 32'd0, OP_SLT);

        applyStimulus("wr_r7", 1, 5'd7, 32'h0000_0011, 5'd0, 5'd0, 0, 32'd0, OP_ADD);
        applyStimulus("we_off", 0, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd0, 0, 32'd0, OP_ADD);
        applyStimulus("r7_kept", 0, 5'd0, 32'd0, 5'd7, 5'd7, 0, 32'd0, OP_OR);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] wd;
            case ($urandom_range(0, 3))
                0:       wd = 32'h8000_0000 + ($urandom_range(0, 2) - 1);
                1:       wd = $urandom_range(0, 3);
                default: wd = $urandom;
            endcase
            applyStimulus("random", bit'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), wd,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          bit'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)));
        end

        // Asynchronous reset in the middle of a write cycle clears everything.
        applyStimulus("pre_mid_rst", 1, 5'd9, 32'hCAFE_F00D, 5'd7, 5'd3, 0, 32'd0, OP_OR);
        @(negedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        pendWe = 1'b0;
        applyStimulus("mid_rst", 1, 5'd9, 32'h5555_5555, 5'd9, 5'd7, 0, 32'd0, OP_ADD);
        setReset(1'b1);
        applyStimulus("after_mid_rst", 0, 5'd0, 32'd0, 5'd9, 5'd3, 0, 32'd0, OP_OR);

        for (int k = 0; k < 20 && scoreboard.size() > 0; k++) @(posedge clk);
        if (scoreboard.size() > 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", scoreboard.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
